// File: rtl/uart_irq_pkg.sv
// -----------------------------------------------------------------------------
// uart_irq_pkg
// Shared definitions for the UART interrupt controller:
//   - FSM state encoding
//   - interrupt ID constants (value reported on Int_ID)
//   - bit positions of each flag inside the 4-bit flag/enable/status vectors
//   - default hold-off length and a helper that clamps it to a legal value
// -----------------------------------------------------------------------------
package uart_irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_CLR    = 2'd2,
    ST_HOLD   = 2'd3
  } irq_state_e;

  // Interrupt source IDs; a higher ID means a higher priority.
  localparam logic [1:0] ID_TFE = 2'd0;
  localparam logic [1:0] ID_THE = 2'd1;
  localparam logic [1:0] ID_RDA = 2'd2;
  localparam logic [1:0] ID_RTO = 2'd3;

  // Bit positions in {RTO,RDA,THE,TFE}-ordered vectors (flags, IE, ISR).
  localparam int BIT_TFE = 0;
  localparam int BIT_THE = 1;
  localparam int BIT_RDA = 2;
  localparam int BIT_RTO = 3;

  localparam int HOLDOFF_DEFAULT = 4;

  // A hold-off of zero or less would leave no time for the flag block to
  // react to Clr_Int, so it is raised to one cycle.
  function automatic int holdoff_eff(input int h);
    return (h < 1) ? 1 : h;
  endfunction

endpackage

// File: rtl/uart_irq_prio.sv
// -----------------------------------------------------------------------------
// uart_irq_prio
// Combinational 4:2 fixed-priority encoder: RTO > RDA > THE > TFE.
// Ports:
//   req   in  4 : pending requests, {RTO,RDA,THE,TFE}
//   id    out 2 : ID of the highest-priority active request (ID_TFE if none)
//   valid out 1 : at least one request is active
// -----------------------------------------------------------------------------
module uart_irq_prio
  import uart_irq_pkg::*;
(
  input  logic [3:0] req,
  output logic [1:0] id,
  output logic       valid
);

  always_comb begin
    valid = |req;
    id    = ID_TFE;
    if (req[BIT_RTO])      id = ID_RTO;
    else if (req[BIT_RDA]) id = ID_RDA;
    else if (req[BIT_THE]) id = ID_THE;
    else                   id = ID_TFE;
  end

endmodule

// File: rtl/uart_irq_ctrl.sv
// -----------------------------------------------------------------------------
// uart_irq_ctrl
// UART interrupt controller. Masks the raw interrupt flags with the enable
// register, raises IRQ to the host, and on a status read snapshots the raw
// flags into ISR and sends a one-cycle Clr_Int pulse back to the flag block.
// After the clear, IRQ is held off for HOLDOFF cycles so the flag block has
// time to drop the flags it just cleared.
// Ports:
//   Clk     in  1 : rising-edge clock
//   Rst     in  1 : asynchronous active-high reset
//   iTFE/iTHE/iRDA/iRTO in 1 : raw interrupt flags
//   WE_IE   in  1 : enable-register write strobe
//   DI      in  4 : enable write data {RTO,RDA,THE,TFE}
//   Rd_ISR  in  1 : host read strobe of the status register
//   IE      out 4 : enable register
//   ISR     out 4 : status snapshot {RTO,RDA,THE,TFE}
//   Int_ID  out 2 : highest-priority pending source (held when none pending)
//   IRQ     out 1 : interrupt request (high only in ASSERT)
//   Clr_Int out 1 : one-cycle clear pulse to the flag block
// -----------------------------------------------------------------------------
module uart_irq_ctrl
  import uart_irq_pkg::*;
#(
  parameter int HOLDOFF = HOLDOFF_DEFAULT
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       iTFE,
  input  logic       iTHE,
  input  logic       iRDA,
  input  logic       iRTO,
  input  logic       WE_IE,
  input  logic [3:0] DI,
  input  logic       Rd_ISR,
  output logic [3:0] IE,
  output logic [3:0] ISR,
  output logic [1:0] Int_ID,
  output logic       IRQ,
  output logic       Clr_Int
);

  localparam int HOLD_EFF = holdoff_eff(HOLDOFF);
  localparam int CNT_W    = $clog2(HOLD_EFF) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_EFF - 1);

  irq_state_e       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       flags;
  logic [3:0]       pending;
  logic [1:0]       prio_id;
  logic             prio_valid;

  always_comb begin
    flags          = '0;
    flags[BIT_TFE] = iTFE;
    flags[BIT_THE] = iTHE;
    flags[BIT_RDA] = iRDA;
    flags[BIT_RTO] = iRTO;
  end

  assign pending = flags & IE;

  uart_irq_prio u_prio (
    .req   (pending),
    .id    (prio_id),
    .valid (prio_valid)
  );

  // Enable register: writable in every state, takes effect next cycle.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      IE <= '0;
    end else if (WE_IE) begin
      IE <= DI;
    end
  end

  // Int_ID tracks the highest pending source and keeps its last value
  // while nothing is pending, so the host still sees the last cause.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Int_ID <= ID_TFE;
    end else if (prio_valid) begin
      Int_ID <= prio_id;
    end
  end

  // Interrupt FSM with registered IRQ / Clr_Int / ISR and hold-off counter.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      ISR       <= '0;
      IRQ       <= 1'b0;
      Clr_Int   <= 1'b0;
    end else begin
      Clr_Int <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (prio_valid) begin
            state_reg <= ST_ASSERT;
            IRQ       <= 1'b1;
          end
        end
        ST_ASSERT: begin
          // A read wins over pending dropping in the same cycle. The
          // snapshot is of raw flags because the clear wipes every set flag,
          // masked or not, and the host must be able to see them all.
          if (Rd_ISR) begin
            ISR       <= flags;
            state_reg <= ST_CLR;
            IRQ       <= 1'b0;
            Clr_Int   <= 1'b1;
          end else if (!prio_valid) begin
            state_reg <= ST_IDLE;
            IRQ       <= 1'b0;
          end
        end
        ST_CLR: begin
          cnt_reg   <= CNT_LOAD;
          state_reg <= ST_HOLD;
          IRQ       <= 1'b0;
        end
        ST_HOLD: begin
          IRQ <= 1'b0;
          if (cnt_reg == '0) begin
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          IRQ       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_irq_ctrl
// Directed scenarios followed by random flag/enable/read traffic. Expected
// outputs come from a timeline model: IRQ may rise only when something is
// pending and the last accepted read is at least HOLDOFF+2 edges in the past.
// -----------------------------------------------------------------------------
module tb_uart_irq_ctrl;

  localparam int H = 4;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       iTFE, iTHE, iRDA, iRTO;
  logic       WE_IE, Rd_ISR;
  logic [3:0] DI;
  logic [3:0] IE, ISR;
  logic [1:0] Int_ID;
  logic       IRQ, Clr_Int;

  always #5 Clk = ~Clk;

  uart_irq_ctrl #(.HOLDOFF(H)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .iTFE    (iTFE),
    .iTHE    (iTHE),
    .iRDA    (iRDA),
    .iRTO    (iRTO),
    .WE_IE   (WE_IE),
    .DI      (DI),
    .Rd_ISR  (Rd_ISR),
    .IE      (IE),
    .ISR     (ISR),
    .Int_ID  (Int_ID),
    .IRQ     (IRQ),
    .Clr_Int (Clr_Int)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_read;

  // Reference model state (expected values of the DUT outputs).
  logic [3:0] m_ie, m_isr;
  logic [1:0] m_id;
  logic       m_irq, m_clr;
  logic [3:0] flags;

  task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ie      = '0;
    m_isr     = '0;
    m_id      = '0;
    m_irq     = 1'b0;
    m_clr     = 1'b0;
    last_read = -1000;
  endtask

  task automatic check_all(input string pfx);
    check_val({pfx, "_IRQ"},    {3'b0, IRQ},     {3'b0, m_irq});
    check_val({pfx, "_ClrInt"}, {3'b0, Clr_Int}, {3'b0, m_clr});
    check_val({pfx, "_IE"},     IE,              m_ie);
    check_val({pfx, "_ISR"},    ISR,             m_isr);
    check_val({pfx, "_IntID"},  {2'b0, Int_ID},  {2'b0, m_id});
  endtask

  // One clock: drive at the falling edge, predict, check 1 time unit after
  // the rising edge, return at the next falling edge.
  task automatic step(input logic [3:0] f, input logic we, input logic [3:0] di, input logic rd);
    logic [3:0] pend;
    logic       n_irq;
    {iRTO, iRDA, iTHE, iTFE} = f;
    WE_IE  = we;
    DI     = di;
    Rd_ISR = rd;
    pend   = f & m_ie;
    n_irq  = (pend != 4'd0) && !(m_irq && rd) && (cyc >= last_read + 2 + H);
    m_clr  = m_irq && rd;
    if (m_clr) begin
      m_isr     = f;
      last_read = cyc;
    end
    for (int b = 0; b < 4; b++) begin
      if (pend[b]) m_id = 2'(b);
    end
    if (we) m_ie = di;
    m_irq = n_irq;
    @(posedge Clk);
    #1;
    $display("cyc=%0d flags=%b we=%b di=%b rd=%b | IRQ=%b Clr=%b IE=%b ISR=%b ID=%0d",
             cyc, f, we, di, rd, IRQ, Clr_Int, IE, ISR, Int_ID);
    check_all("step");
    cyc++;
    @(negedge Clk);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 1'b0, 4'b0000, 1'b0);
  endtask

  initial begin
    Rst = 1'b1;
    {iRTO, iRDA, iTHE, iTFE} = 4'b0000;
    WE_IE = 1'b0; DI = 4'b0000; Rd_ISR = 1'b0;
    model_reset();
    flags = '0;
    repeat (2) @(posedge Clk);
    #1;
    check_all("reset");
    @(negedge Clk);
    Rst = 1'b0;

    // RDA only: IRQ after one cycle, read, clear pulse, hold-off.
    step(4'b0000, 1'b1, 4'b0100, 1'b0);
    step(4'b0100, 1'b0, 4'b0000, 1'b0);
    check_val("rda_irq", {3'b0, IRQ}, 4'b0001);
    check_val("rda_id", {2'b0, Int_ID}, 4'd2);
    step(4'b0100, 1'b0, 4'b0000, 1'b1);
    check_val("rda_isr", ISR, 4'b0100);
    check_val("rda_clr", {3'b0, Clr_Int}, 4'b0001);
    step(4'b0100, 1'b0, 4'b0000, 1'b0);   // flag block clears at this edge
    check_val("rda_clr_once", {3'b0, Clr_Int}, 4'b0000);
    idle_steps(H + 2);

    // RTO and TFE together: RTO wins, snapshot holds both.
    step(4'b0000, 1'b1, 4'b1111, 1'b0);
    step(4'b1001, 1'b0, 4'b0000, 1'b0);
    check_val("multi_id", {2'b0, Int_ID}, 4'd3);
    step(4'b1001, 1'b0, 4'b0000, 1'b1);
    check_val("multi_isr", ISR, 4'b1001);
    idle_steps(H + 3);

    // Masked THE, then enable it: IRQ two cycles after the write.
    step(4'b0000, 1'b1, 4'b0000, 1'b0);
    step(4'b0010, 1'b0, 4'b0000, 1'b0);
    step(4'b0010, 1'b0, 4'b0000, 1'b1);   // read ignored in IDLE
    check_val("masked_irq", {3'b0, IRQ}, 4'b0000);
    step(4'b0010, 1'b1, 4'b0010, 1'b0);
    step(4'b0010, 1'b0, 4'b0000, 1'b0);
    check_val("unmask_irq", {3'b0, IRQ}, 4'b0001);
    step(4'b0010, 1'b1, 4'b0101, 1'b1);   // read + enable write together
    check_val("rdwe_clr", {3'b0, Clr_Int}, 4'b0001);
    idle_steps(H + 3);

    // Self-cleared flag in ASSERT, then TFE raised during hold-off.
    step(4'b0100, 1'b0, 4'b0000, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 1'b0);
    check_val("drop_irq", {3'b0, IRQ}, 4'b0000);
    check_val("drop_noclr", {3'b0, Clr_Int}, 4'b0000);
    step(4'b0100, 1'b0, 4'b0000, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 1'b1);   // read coincident with drop wins
    check_val("drop_rd_clr", {3'b0, Clr_Int}, 4'b0001);
    step(4'b0000, 1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < H + 3; i++) step(4'b0001, 1'b0, 4'b0000, 1'b0);
    check_val("hold_rearm", {3'b0, IRQ}, 4'b0001);
    step(4'b0001, 1'b0, 4'b0000, 1'b1);
    step(4'b0000, 1'b0, 4'b0000, 1'b0);
    idle_steps(H + 2);

    // Reset while Clr_Int is high.
    step(4'b0100, 1'b0, 4'b0000, 1'b0);
    step(4'b0100, 1'b0, 4'b0000, 1'b1);
    check_val("pre_rst_clr", {3'b0, Clr_Int}, 4'b0001);
    Rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge Clk);
    Rst = 1'b0;
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, 4'b0000, 1'b1);

    // Random traffic with a flag block that clears on Clr_Int.
    flags = '0;
    for (int n = 0; n < 1500; n++) begin
      if (m_clr) flags = '0;
      for (int b = 0; b < 4; b++) begin
        case ($urandom_range(0, 15))
          0:       flags[b] = 1'b1;
          1:       flags[b] = 1'b0;
          default: ;
        endcase
      end
      step(flags, ($urandom_range(0, 9) == 0), 4'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
